// File: rtl/sram_pkg.sv
// Shared definitions for the SRAM access arbiter slice.
// Holds the bus widths, the requester identifiers and the packed request
// bundle that the top level muxes onto the sram_core pins.
package sram_pkg;

    localparam int unsigned ADDR_W = 14;
    localparam int unsigned ROW_W  = 13;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned LANES  = 4;

    typedef enum logic [0:0] {
        REQ_AHB = 1'b0,
        REQ_DMA = 1'b1
    } req_id_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [LANES-1:0]  be;
        logic [DATA_W-1:0] wdata;
    } sram_req_t;

endpackage

// File: rtl/sram_rr_arb.sv
// Two-way grant logic for the SRAM arbiter.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_req0, i_req1   access requests (AHB, DMA)
//   i_lock           keep the previous cycle's winner while it requests
//   o_gnt0, o_gnt1   combinational one-hot (or zero) grant
// PRIO_MODE 0 is round-robin; 1 gives requester 0 fixed priority with
// aging so requester 1 is forced through after MAX_WAIT refusals.
module sram_rr_arb
    import sram_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_lock,
    output logic o_gnt0,
    output logic o_gnt1
);

    localparam logic [3:0] LP_MAX_WAIT = 4'(MAX_WAIT);

    req_id_e    r_last_gnt;
    logic       r_gnt_vld;   // previous cycle granted someone
    logic [3:0] r_wait_cnt;
    logic       w_lock_hold;

    assign w_lock_hold = i_lock && r_gnt_vld;

    always_comb begin
        o_gnt0 = 1'b0;
        o_gnt1 = 1'b0;
        if (w_lock_hold && (r_last_gnt == REQ_AHB) && i_req0) begin
            o_gnt0 = 1'b1;
        end else if (w_lock_hold && (r_last_gnt == REQ_DMA) && i_req1) begin
            o_gnt1 = 1'b1;
        end else if (PRIO_MODE == 0) begin
            if (i_req0 && i_req1) begin
                if (r_last_gnt == REQ_AHB) o_gnt1 = 1'b1;
                else                       o_gnt0 = 1'b1;
            end else begin
                o_gnt0 = i_req0;
                o_gnt1 = i_req1;
            end
        end else begin
            if (i_req1 && (!i_req0 || (r_wait_cnt == LP_MAX_WAIT))) o_gnt1 = 1'b1;
            else                                                     o_gnt0 = i_req0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_last_gnt <= REQ_DMA;
            r_gnt_vld  <= 1'b0;
            r_wait_cnt <= '0;
        end else begin
            r_gnt_vld <= o_gnt0 || o_gnt1;
            if (o_gnt0 || o_gnt1) r_last_gnt <= o_gnt1 ? REQ_DMA : REQ_AHB;
            // Saturate at MAX_WAIT so a lock-extended wait still triggers aging.
            if (!i_req1 || o_gnt1)               r_wait_cnt <= '0;
            else if (r_wait_cnt < LP_MAX_WAIT)   r_wait_cnt <= r_wait_cnt + 4'd1;
        end
    end

endmodule

// File: rtl/sram_arb.sv
// Two-requester arbiter and sequencer in front of sram_core.
// Ports:
//   hclk, hresetn             clock, asynchronous active-low reset
//   m0_* / m1_*               AHB / DMA request, grant and read-valid
//   rdata                     shared read data, qualified by mX_rvalid
//   lock                      previous winner keeps priority while high
//   sram_wen, sram_addr,
//   sram_wdata_in,
//   bank0_csn, bank1_csn      sram_core control (active-low selects)
//   sram_q0..sram_q7          macro outputs, bank 0 bytes then bank 1 bytes
module sram_arb
    import sram_pkg::*;
#(
    parameter int unsigned PRIO_MODE = 0,
    parameter int unsigned MAX_WAIT  = 8
) (
    input  logic              hclk,
    input  logic              hresetn,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [LANES-1:0]  m0_be,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_gnt,
    output logic              m0_rvalid,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [LANES-1:0]  m1_be,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_gnt,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] rdata,
    input  logic              lock,
    output logic              sram_wen,
    output logic [ROW_W-1:0]  sram_addr,
    output logic [DATA_W-1:0] sram_wdata_in,
    output logic [LANES-1:0]  bank0_csn,
    output logic [LANES-1:0]  bank1_csn,
    input  logic [7:0]        sram_q0,
    input  logic [7:0]        sram_q1,
    input  logic [7:0]        sram_q2,
    input  logic [7:0]        sram_q3,
    input  logic [7:0]        sram_q4,
    input  logic [7:0]        sram_q5,
    input  logic [7:0]        sram_q6,
    input  logic [7:0]        sram_q7
);

    sram_req_t         w_r0, w_r1, w_sel;
    logic              w_gnt0, w_gnt1, w_any, w_bank, w_rd;
    logic [LANES-1:0]  w_lane_csn;

    logic              r_rvalid0, r_rvalid1, r_rd_bank;
    logic [DATA_W-1:0] r_word0, r_word1;

    sram_rr_arb #(
        .PRIO_MODE (PRIO_MODE),
        .MAX_WAIT  (MAX_WAIT)
    ) u_arb (
        .i_clk   (hclk),
        .i_rst_n (hresetn),
        .i_req0  (m0_req),
        .i_req1  (m1_req),
        .i_lock  (lock),
        .o_gnt0  (w_gnt0),
        .o_gnt1  (w_gnt1)
    );

    assign w_r0       = '{we: m0_we, addr: m0_addr, be: m0_be, wdata: m0_wdata};
    assign w_r1       = '{we: m1_we, addr: m1_addr, be: m1_be, wdata: m1_wdata};
    assign w_sel      = w_gnt1 ? w_r1 : w_r0;
    assign w_any      = w_gnt0 || w_gnt1;
    assign w_bank     = w_sel.addr[ADDR_W-1];
    assign w_rd       = w_any && !w_sel.we;
    // A zero byte-enable write leaves every lane deselected: a granted no-op.
    assign w_lane_csn = w_sel.we ? ~w_sel.be : '0;

    assign m0_gnt = w_gnt0;
    assign m1_gnt = w_gnt1;

    always_comb begin
        sram_wen      = 1'b1;
        sram_addr     = '0;
        sram_wdata_in = '0;
        bank0_csn     = '1;
        bank1_csn     = '1;
        if (w_any) begin
            sram_wen      = ~w_sel.we;
            sram_addr     = w_sel.addr[ROW_W-1:0];
            sram_wdata_in = w_sel.wdata;
            if (w_bank) bank1_csn = w_lane_csn;
            else        bank0_csn = w_lane_csn;
        end
    end

    // The macro samples on the falling edge mid-cycle, so its q outputs are
    // settled by the rising edge that ends the grant cycle.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rd_bank <= 1'b0;
            r_word0   <= '0;
            r_word1   <= '0;
        end else begin
            r_rvalid0 <= w_gnt0 && !m0_we;
            r_rvalid1 <= w_gnt1 && !m1_we;
            if (w_rd) begin
                r_rd_bank <= w_bank;
                r_word0   <= {sram_q3, sram_q2, sram_q1, sram_q0};
                r_word1   <= {sram_q7, sram_q6, sram_q5, sram_q4};
            end
        end
    end

    assign m0_rvalid = r_rvalid0;
    assign m1_rvalid = r_rvalid1;
    assign rdata     = r_rd_bank ? r_word1 : r_word0;

endmodule
